csa_result_fifo: RTL and testbench

//  Registered capture stage directly downstream of the 34-bit carry-select adder.

---
 rtl/csa_result_fifo.sv | 73 +++++++
 tb/tb_csa_result_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_result_fifo.sv
// Capture stage behind the carry-select adder: FWFT FIFO of {cout,sum} results
// plus a saturating count of accepted results whose carry-out was set.
module csa_result_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [WIDTH-1:0]         i_sum,
  input  logic                     i_cout,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [WIDTH:0]           o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  input  logic                     i_clr_stats,
  output logic [CNT_W-1:0]         o_ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CNT_W-1:0] ovf_cnt;
  logic            push;
  logic            pop;

  // Ready depends only on registered occupancy, so a full FIFO never accepts
  // a push even when the consumer pops in the same cycle.
  assign o_ready   = (count != FULL_CNT);
  assign o_valid   = (count != '0);
  assign o_data    = mem[rd_ptr];
  assign o_count   = count;
  assign o_ovf_cnt = ovf_cnt;

  assign push = i_valid & o_ready;
  assign pop  = o_valid & i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {i_cout, i_sum};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Clear wins over a same-cycle counted push; the counter sticks at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ovf_cnt <= '0;
    end else if (i_clr_stats) begin
      ovf_cnt <= '0;
    end else if (push && i_cout && (ovf_cnt != {CNT_W{1'b1}})) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_csa_result_fifo.sv
// Directed bench for csa_result_fifo: a default instance and a CNT_W=4 instance
// share all inputs so the saturation behaviour can be observed quickly.
module tb_csa_result_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [33:0] sum;
  logic        cout;
  logic        valid;
  logic        ready;
  logic        clr;
  logic        o_ready;
  logic [34:0] o_data;
  logic        o_valid;
  logic [2:0]  o_count;
  logic [15:0] ovf16;
  logic        o_ready4;
  logic [34:0] o_data4;
  logic        o_valid4;
  logic [2:0]  o_count4;
  logic [3:0]  ovf4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csa_result_fifo dut (
    .i_clk(clk), .i_rst(rst), .i_sum(sum), .i_cout(cout), .i_valid(valid),
    .o_ready(o_ready), .o_data(o_data), .o_valid(o_valid), .i_ready(ready),
    .o_count(o_count), .i_clr_stats(clr), .o_ovf_cnt(ovf16)
  );

  csa_result_fifo #(.WIDTH(34), .DEPTH(4), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_sum(sum), .i_cout(cout), .i_valid(valid),
    .o_ready(o_ready4), .o_data(o_data4), .o_valid(o_valid4), .i_ready(ready),
    .o_count(o_count4), .i_clr_stats(clr), .o_ovf_cnt(ovf4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sum = 34'h3_1234_5678; cout = 1'b1; valid = 1'b0; ready = 1'b0; clr = 1'b0;
    step(); step();
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_held valid=%b ready=%b count=%0d expected 0/1/0", o_valid, o_ready, o_count);
    end
    rst = 1'b0;
    step(); step();
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_count !== 3'd0 || o_data !== 35'd0 || ovf16 !== 16'd0 || ovf4 !== 4'd0) begin
      failures++;
      $display("[TB] FAIL reset_idle valid=%b ready=%b count=%0d data=%h ovf=%0d expected 0/1/0/0/0", o_valid, o_ready, o_count, o_data, ovf16);
    end
  endtask

  task automatic test_single_pass();
    sum = 34'h3_FFFF_FFFF; cout = 1'b1; valid = 1'b1;
    step();
    valid = 1'b0; cout = 1'b0;
    checks++;
    if (o_valid !== 1'b1 || o_data !== 35'h7_FFFF_FFFF || ovf16 !== 16'd1 || o_count !== 3'd1) begin
      failures++;
      $display("[TB] FAIL single_push valid=%b data=%h ovf=%0d count=%0d expected 1/7ffffffff/1/1", o_valid, o_data, ovf16, o_count);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL single_pop valid=%b count=%0d expected 0/0", o_valid, o_count);
    end
  endtask

  task automatic test_fill_full();
    for (int k = 1; k <= 5; k++) begin
      sum = 34'(k); cout = 1'b0; valid = 1'b1; ready = 1'b0;
      checks++;
      if (o_ready !== (k <= 4)) begin
        failures++;
        $display("[TB] FAIL fill_ready k=%0d ready=%b expected %b", k, o_ready, (k <= 4));
      end
      step();
    end
    checks++;
    if (o_count !== 3'd4 || o_ready !== 1'b0 || o_data !== 35'd1) begin
      failures++;
      $display("[TB] FAIL full_state count=%0d ready=%b data=%h expected 4/0/1", o_count, o_ready, o_data);
    end
    ready = 1'b1;
    step();
    checks++;
    if (o_count !== 3'd3 || o_ready !== 1'b1 || o_data !== 35'd2) begin
      failures++;
      $display("[TB] FAIL full_pop count=%0d ready=%b data=%h expected 3/1/2", o_count, o_ready, o_data);
    end
    ready = 1'b0;
    step();
    valid = 1'b0;
    checks++;
    if (o_count !== 3'd4) begin
      failures++;
      $display("[TB] FAIL fifth_accept count=%0d expected 4", o_count);
    end
    ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== 35'(k)) begin
        failures++;
        $display("[TB] FAIL drain_order valid=%b data=%h expected 1/%h", o_valid, o_data, k);
      end
      step();
    end
    ready = 1'b0;
    checks++;
    if (o_count !== 3'd0 || o_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL drain_empty count=%0d valid=%b expected 0/0", o_count, o_valid);
    end
  endtask

  task automatic test_back_to_back();
    valid = 1'b1; ready = 1'b0; cout = 1'b0;
    sum = 34'd100; step();
    sum = 34'd101; step();
    ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sum = 34'(102 + i);
      checks++;
      if (o_count !== 3'd2 || o_data !== 35'(100 + i)) begin
        failures++;
        $display("[TB] FAIL wrap_simul i=%0d count=%0d data=%0d expected 2/%0d", i, o_count, o_data, 100 + i);
      end
      step();
    end
    valid = 1'b0;
    for (int i = 120; i <= 121; i++) begin
      checks++;
      if (o_data !== 35'(i) || o_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL wrap_drain data=%0d valid=%b expected %0d/1", o_data, o_valid, i);
      end
      step();
    end
    ready = 1'b0;
    checks++;
    if (o_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL wrap_empty count=%0d expected 0", o_count);
    end
  endtask

  task automatic test_saturation();
    clr = 1'b1; valid = 1'b0; cout = 1'b1;
    step();
    clr = 1'b0;
    step();
    checks++;
    if (ovf4 !== 4'd0 || ovf16 !== 16'd0 || o_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL nopush_cout ovf4=%0d ovf16=%0d count=%0d expected 0/0/0", ovf4, ovf16, o_count);
    end
    valid = 1'b1; ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      sum = 34'(i);
      step();
      if (i == 14 || i == 16) begin
        checks++;
        if (ovf4 !== ((i == 14) ? 4'd14 : 4'd15)) begin
          failures++;
          $display("[TB] FAIL sat_progress i=%0d ovf4=%0d expected %0d", i, ovf4, (i == 14) ? 14 : 15);
        end
      end
    end
    checks++;
    if (ovf4 !== 4'd15 || ovf16 !== 16'd17) begin
      failures++;
      $display("[TB] FAIL sat_final ovf4=%0d ovf16=%0d expected 15/17", ovf4, ovf16);
    end
    clr = 1'b1;
    step();
    clr = 1'b0; valid = 1'b0;
    checks++;
    if (ovf4 !== 4'd0 || ovf16 !== 16'd0) begin
      failures++;
      $display("[TB] FAIL clr_priority ovf4=%0d ovf16=%0d expected 0/0", ovf4, ovf16);
    end
    step();
    ready = 1'b0; cout = 1'b0;
    checks++;
    if (o_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL sat_empty count=%0d expected 0", o_count);
    end
  endtask

  task automatic test_async_reset();
    valid = 1'b1; ready = 1'b0; cout = 1'b0;
    sum = 34'hA; step();
    sum = 34'hB; step();
    sum = 34'hC; step();
    valid = 1'b0;
    checks++;
    if (o_count !== 3'd3 || o_data !== 35'hA) begin
      failures++;
      $display("[TB] FAIL pre_reset count=%0d data=%h expected 3/a", o_count, o_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_count !== 3'd0 || o_data !== 35'd0) begin
      failures++;
      $display("[TB] FAIL async_reset valid=%b ready=%b count=%0d data=%h expected 0/1/0/0", o_valid, o_ready, o_count, o_data);
    end
    step();
    rst = 1'b0;
    ready = 1'b1;
    step(); step();
    checks++;
    if (o_valid !== 1'b0 || o_count !== 3'd0) begin
      failures++;
      $display("[TB] FAIL post_reset_stale valid=%b count=%0d expected 0/0", o_valid, o_count);
    end
    ready = 1'b0; valid = 1'b1; sum = 34'hD;
    step();
    valid = 1'b0;
    checks++;
    if (o_data !== 35'hD || o_count !== 3'd1) begin
      failures++;
      $display("[TB] FAIL post_reset_push data=%h count=%0d expected d/1", o_data, o_count);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset_drain valid=%b expected 0", o_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_fill_full();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
